// File: rtl/wm_pkg.sv
// Shared types for the washing-machine cycle timer.
// Timer FSM state encoding and TIMER_SEL duration codes.
package wm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } tmr_state_e;

  typedef enum logic [1:0] {
    SEL_DEF  = 2'b00,
    SEL_MED  = 2'b01,
    SEL_HIGH = 2'b10,
    SEL_SPIN = 2'b11
  } tmr_sel_e;

endpackage

// File: rtl/wm_prescaler.sv
// Modulo-TICK_DIV cycle counter producing the 1 s tick.
// o_wrap flags the terminal count; the owner decides whether it is consumed.
module wm_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_hold,
  output logic o_wrap
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;

  assign o_wrap = (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      r_cnt <= o_wrap ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/wm_cycle_timer.sv
// Wash/spin phase timer: prescaled 1 s tick drives a seconds down-counter.
// Supports pause (hold) and abort; all outputs registered.
module wm_cycle_timer
  import wm_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 12,
  parameter int T_SEL0   = 60,
  parameter int T_SEL1   = 1200,
  parameter int T_SEL2   = 1800,
  parameter int T_SEL3   = 600
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TIMER_EN,
  input  logic [1:0]       TIMER_SEL,
  input  logic             PAUSE,
  output logic             TIMER_DONE,
  output logic             BUSY,
  output logic             TICK,
  output logic [CNT_W-1:0] REMAINING
);

  tmr_state_e       r_state;
  tmr_state_e       w_nxt;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] w_rem_nxt;
  logic [CNT_W-1:0] w_dur;
  logic             r_done;
  logic             r_busy;
  logic             r_tick;
  logic             w_tick_nxt;
  logic             w_clr;
  logic             w_hold;
  logic             w_wrap;

  wm_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .i_clk  (CLK),
    .i_rst_n(RST),
    .i_clr  (w_clr),
    .i_hold (w_hold),
    .o_wrap (w_wrap)
  );

  always_comb begin
    w_dur = CNT_W'(T_SEL0);
    unique case (tmr_sel_e'(TIMER_SEL))
      SEL_DEF:  w_dur = CNT_W'(T_SEL0);
      SEL_MED:  w_dur = CNT_W'(T_SEL1);
      SEL_HIGH: w_dur = CNT_W'(T_SEL2);
      SEL_SPIN: w_dur = CNT_W'(T_SEL3);
    endcase
  end

  always_comb begin
    w_nxt      = r_state;
    w_rem_nxt  = r_rem;
    w_tick_nxt = 1'b0;
    w_clr      = 1'b0;
    w_hold     = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        w_clr     = 1'b1;
        w_rem_nxt = '0;
        if (TIMER_EN) begin
          w_nxt     = ST_RUN;
          w_rem_nxt = w_dur;
        end
      end
      ST_RUN, ST_PAUSED: begin
        // abort beats pause, which beats a pending tick
        if (!TIMER_EN) begin
          w_nxt     = ST_IDLE;
          w_rem_nxt = '0;
          w_clr     = 1'b1;
        end else if (PAUSE) begin
          w_nxt = ST_PAUSED;
        end else if (r_rem == '0) begin
          w_nxt = ST_DONE;
          w_clr = 1'b1;
        end else begin
          w_nxt  = ST_RUN;
          w_hold = 1'b0;
          if (w_wrap) begin
            w_tick_nxt = 1'b1;
            w_rem_nxt  = r_rem - CNT_W'(1);
            if (r_rem == CNT_W'(1)) begin
              w_nxt = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        w_clr     = 1'b1;
        w_rem_nxt = '0;
        if (!TIMER_EN) begin
          w_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_rem   <= w_rem_nxt;
      r_done  <= (w_nxt == ST_DONE);
      r_busy  <= (w_nxt == ST_RUN) || (w_nxt == ST_PAUSED);
      r_tick  <= w_tick_nxt;
    end
  end

  assign TIMER_DONE = r_done;
  assign BUSY       = r_busy;
  assign TICK       = r_tick;
  assign REMAINING  = r_rem;

endmodule

// File: tb/tb_wm_cycle_timer.sv
// Randomized + directed bench for wm_cycle_timer.
// Reference model counts active cycles against duration*TICK_DIV.
module tb_wm_cycle_timer;

  localparam int DIV = 4;
  localparam int CW  = 12;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          TIMER_EN = 1'b0;
  logic [1:0]    TIMER_SEL = 2'b00;
  logic          PAUSE = 1'b0;
  logic          TIMER_DONE;
  logic          BUSY;
  logic          TICK;
  logic [CW-1:0] REMAINING;

  int total = 0;
  int bad   = 0;

  // model: 0 idle, 1 active, 2 done
  int m_ph   = 0;
  int m_sec  = 0;
  int m_act  = 0;
  int m_tick = 0;

  wm_cycle_timer #(
    .TICK_DIV(DIV), .CNT_W(CW),
    .T_SEL0(2), .T_SEL1(3), .T_SEL2(5), .T_SEL3(0)
  ) dut (
    .CLK(CLK), .RST(RST), .TIMER_EN(TIMER_EN),
    .TIMER_SEL(TIMER_SEL), .PAUSE(PAUSE),
    .TIMER_DONE(TIMER_DONE), .BUSY(BUSY),
    .TICK(TICK), .REMAINING(REMAINING)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur(input int sel);
    case (sel)
      0: return 2;
      1: return 3;
      2: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    m_ph = 0; m_sec = 0; m_act = 0; m_tick = 0;
  endtask

  task automatic m_edge(input bit en, input int sel, input bit pz);
    m_tick = 0;
    case (m_ph)
      0: if (en) begin
        m_ph = 1; m_sec = dur(sel); m_act = 0;
      end
      1: if (!en) begin
        m_ph = 0;
      end else if (!pz) begin
        if (m_sec == 0) m_ph = 2;
        else begin
          m_act++;
          if (m_act % DIV == 0) m_tick = 1;
          if (m_act == m_sec * DIV) m_ph = 2;
        end
      end
      default: if (!en) m_ph = 0;
    endcase
  endtask

  task automatic cmp_all(input string tag);
    int er;
    er = (m_ph == 1) ? m_sec - m_act / DIV : 0;
    chk({tag, ".rem"}, int'(REMAINING), er);
    chk({tag, ".done"}, int'(TIMER_DONE), int'(m_ph == 2));
    chk({tag, ".busy"}, int'(BUSY), int'(m_ph == 1));
    chk({tag, ".tick"}, int'(TICK), m_tick);
  endtask

  // inputs applied after negedge, sampled at posedge, outputs checked at negedge
  task automatic cyc(input bit en, input int sel, input bit pz, input string tag);
    TIMER_EN = en; TIMER_SEL = 2'(sel); PAUSE = pz;
    @(posedge CLK);
    if (RST) m_edge(en, sel, pz);
    @(negedge CLK);
    cmp_all(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, "idle");
  endtask

  int n;
  int tick_cnt;

  initial begin
    m_reset();
    #2;
    cmp_all("reset");
    @(negedge CLK);
    RST = 1'b1;
    idle(2);

    // 1: SEL=01, done 12 edges after start edge
    n = 0; tick_cnt = 0;
    do begin
      cyc(1, 1, 0, "t1"); n++;
      tick_cnt += int'(TICK);
    end while (!TIMER_DONE && n < 60);
    chk("t1_latency", n, 13);
    chk("t1_ticks", tick_cnt, 3);
    cyc(1, 1, 0, "t1_hold");
    cyc(0, 1, 0, "t1_clear");
    chk("t1_done_clr", int'(TIMER_DONE), 0);
    idle(1);

    // 2: SEL=10 with 7 paused cycles
    n = 0;
    do begin
      cyc(1, 2, (n >= 6 && n <= 12), "t2"); n++;
    end while (!TIMER_DONE && n < 80);
    chk("t2_latency", n, 28);
    idle(2);

    // 3: SEL=00 abort
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, "t3");
    cyc(0, 0, 0, "t3_abort");
    chk("t3_busy", int'(BUSY), 0);
    idle(3);

    // 4: zero duration
    for (int i = 0; i < 6; i++) cyc(1, 3, 0, "t4");
    idle(2);

    // 5: SEL toggling during a SEL=01 run, then EN held through DONE
    n = 0;
    do begin
      cyc(1, (n == 0) ? 1 : int'($urandom_range(0, 3)), 0, "t5"); n++;
    end while (!TIMER_DONE && n < 60);
    chk("t5_latency", n, 13);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, "t5_norestart");
    idle(2);

    // 6: asynchronous reset mid-run
    for (int i = 0; i < 6; i++) cyc(1, 2, 0, "t6");
    #2 RST = 1'b0;
    #1 m_reset();
    cmp_all("t6_async");
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 14; i++) cyc(1, 1, 0, "t6_restart");
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 12) != 0, int'($urandom_range(0, 3)),
          ($urandom % 6) == 0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
